rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-input resource among 8 requesters.
- Each request line maps to one input of the downstream 8:3 priority-encoded datapath.
- The block decides which single requester owns the resource. It drives a one-hot grant plus the 3-bit encoded index, which is the form the 8:3 encoder consumes.
- A grant is held until its requester releases it, then rotates fairly.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles before forced revoke. Used only with ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk      input   1  rising-edge clock
- rst_n    input   1  asynchronous active-low reset
- en       input   1  arbitration enable; low blocks new grants, existing grant unaffected
- req      input   8  request lines, bit i = requester i, level-sensitive
- gnt      output  8  one-hot grant, registered
- gnt_idx  output  3  binary index of granted requester, registered; 0 when gnt_vld=0
- gnt_vld  output  1  registered; equals |gnt
- timeout  output  1  one-cycle pulse on forced revoke; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=0, state=IDLE, hold_cnt=0. Release is synchronous to clk; the first grant is possible on the first edge after release.
- ptr (3-bit) is the highest-priority requester. Search order is ptr, ptr+1, ... ptr+7, modulo 8.
- Winner = first i in search order with req[i]=1. This is a rotated priority encode.
- State IDLE:
  - If en=1 and req!=0: the next edge sets gnt to the winner, gnt_idx to its index, gnt_vld=1, and moves to GRANT.
  - Latency is one cycle from request sample to grant.
  - Otherwise outputs stay 0.
- State GRANT, holder h:
  - While req[h]=1: outputs hold and ptr holds. Other requests are ignored. en has no effect.
  - When req[h]=0 is sampled: ptr <= h+1 (wrap 7->0).
  - Same edge: if en=1 and (req & ~(1<<h))!=0, grant the winner under the new ptr and stay in GRANT. There is no idle bubble.
  - Same edge, otherwise: clear outputs and go to IDLE.
- Other requester lines changing during a grant never alter gnt.
- gnt is always one-hot or zero. gnt_idx is always consistent with gnt.
- en deasserted while in GRANT: the current holder keeps the grant until release. After release the block goes to IDLE and stays there while en=0.
- All 8 requesting continuously with immediate release after one cycle each: grants go 0,1,2,...,7,0. Each requester is served once per 8 grants.
- A requester dropping req in the same cycle it is granted: the grant lasts exactly one cycle, then the release rules apply.
- Reset asserted mid-grant: outputs clear immediately (asynchronous) and ptr returns to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt counts GRANT cycles for the current holder. It resets to 1 on each new grant.
  - When hold_cnt reaches MAX_HOLD with req[h] still 1, the next edge forcibly revokes: ptr <= h+1, timeout pulses high for 1 cycle, and re-arbitration proceeds exactly as for a release.
  - Only the other requesters are eligible for the next winner. h becomes eligible again on the following arbitration.
- Not defined: no counter is built, timeout is constant 0, and a grant is held indefinitely.

Test Plan:
- Reset then req=8'b0000_0100, en=1 -> one edge later gnt=8'h04, gnt_idx=2, gnt_vld=1; drop req -> next edge gnt=0, gnt_vld=0, ptr=3.
- ptr=3, req=8'b1000_0101 -> gnt_idx=7 (search 3..7 before 0); release 7 -> next edge gnt_idx=0 with no bubble; release 0 -> gnt_idx=2.
- req=8'hFF held, each holder dropping its bit for one cycle after its grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0.
- Grant on idx 5, then en=0, then req[5] dropped while req[1]=1 -> gnt cleared, stays 0 until en=1, then gnt_idx=1.
- Grant active on idx 4, rst_n pulsed low mid-cycle -> gnt, gnt_idx, gnt_vld drop to 0 immediately. After release with req=8'h11 -> gnt_idx=0 (ptr back to 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 held -> idx0 granted 4 cycles, timeout=1 for one cycle, gnt_idx=1 for 4 cycles, timeout, gnt_idx=0 again. Without the macro -> idx0 held indefinitely, timeout=0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- round-robin arbiter for one resource shared by 8 requesters.
//
// A winner keeps the grant for as long as it holds its request line. On
// release the priority pointer moves to the slot after the holder, and the
// next winner (if any) is granted on that same edge, so there is no idle
// bubble between owners.
//
// Optional build macro: ARB_TIMEOUT_EN
//   defined   : a hold counter revokes a grant after MAX_HOLD cycles and
//               pulses 'timeout' for one cycle.
//   undefined : no counter is built, timeout is tied 0 and grants are held
//               for as long as the request stays high.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   arbitration enable (blocks new grants only)
//   req[7:0] in   level-sensitive request lines, bit i = requester i
//   gnt[7:0] out  registered one-hot grant
//   gnt_idx  out  registered binary index of the holder, 0 when idle
//   gnt_vld  out  registered, equals |gnt
//   timeout  out  one-cycle pulse on a forced revoke
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_d;
    logic [2:0] ptr, ptr_d;
    logic [7:0] gnt_d;
    logic [2:0] idx_d;
    logic       vld_d;
    logic       rel;       // holder gives up the resource at this edge
    logic       expire;    // hold limit reached
    logic [3:0] win;       // {found, index}
    logic [7:0] cand;

    // Rotated priority encode: first set bit of r searching p, p+1, ... p+7.
    // Scanning from the far end backwards leaves the nearest hit in res.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            logic [2:0] i;
            i = p + 3'(k);
            if (r[i]) res = {1'b1, i};
        end
        return res;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    assign expire = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD));
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        vld_d   = gnt_vld;
        rel     = 1'b0;
        cand    = req;
        win     = '0;
        case (state)
            IDLE: begin
                win = pick(req, ptr);
                if (en && win[3]) begin
                    gnt_d   = 8'b1 << win[2:0];
                    idx_d   = win[2:0];
                    vld_d   = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                rel = !req[gnt_idx] || expire;
                if (rel) begin
                    // The outgoing holder is not eligible for this round,
                    // even if it is still requesting after a revoke.
                    ptr_d = gnt_idx + 3'd1;
                    cand  = req & ~gnt;
                    win   = pick(cand, ptr_d);
                    if (en && win[3]) begin
                        gnt_d = 8'b1 << win[2:0];
                        idx_d = win[2:0];
                        vld_d = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        idx_d   = '0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            gnt     <= gnt_d;
            gnt_idx <= idx_d;
            gnt_vld <= vld_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // hold_cnt = number of cycles the current holder has owned the grant,
    // 1 in the first cycle it is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state_d == IDLE)
                hold_cnt <= '0;
            else if (state == IDLE || rel)
                hold_cnt <= 8'd1;
            else
                hold_cnt <= hold_cnt + 8'd1;
            // Only a revoke of a still-requesting holder is a timeout.
            timeout <= expire && req[gnt_idx];
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed vector table, hand-written
// reset/timeout sequences, and a randomized run against a reference model.
module tb_rr_arbiter8;

    localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    // ---------------- reference model ----------------
    int m_ptr;
    int m_h;     // holder, -1 when nobody owns the resource
    int m_cnt;
    bit m_to;

    function automatic int winner(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_h = -1; m_cnt = 0; m_to = 0;
    endtask

    task automatic model_step(bit e, logic [7:0] r);
        bit forced;
        logic [7:0] c;
        m_to = 0;
        if (m_h < 0) begin
            if (e && r != 0) begin
                m_h = winner(r, m_ptr);
                m_cnt = 1;
            end
        end else begin
            forced = TO_EN && (m_cnt >= MH) && r[m_h];
            if (r[m_h] && !forced) begin
                m_cnt++;
            end else begin
                m_ptr = (m_h + 1) % 8;
                m_to = forced;
                c = r;
                c[m_h] = 1'b0;
                if (e && c != 0) begin
                    m_h = winner(c, m_ptr);
                    m_cnt = 1;
                end else begin
                    m_h = -1;
                    m_cnt = 0;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic step(bit e, logic [7:0] r);
        en = e;
        req = r;
        @(posedge clk);
        model_step(e, r);
        #1;
    endtask

    task automatic chk(string name, int eidx, bit evld, bit eto);
        logic [7:0] eg;
        eg = evld ? (8'b1 << eidx) : 8'h00;
        n_tests++;
        if (gnt !== eg || gnt_idx !== 3'(evld ? eidx : 0) || gnt_vld !== evld || timeout !== eto) begin
            n_fail++;
            $display("FAIL %s: gnt=%h idx=%0d vld=%b to=%b, expected gnt=%h idx=%0d vld=%b to=%b",
                     name, gnt, gnt_idx, gnt_vld, timeout, eg, evld ? eidx : 0, evld, eto);
        end
    endtask

    task automatic chk_model(string name);
        chk(name, (m_h < 0) ? 0 : m_h, m_h >= 0, m_to);
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear.
    task automatic do_reset(string name);
        rst_n = 1'b0;
        en = 1'b0;
        req = 8'h00;
        #2;
        chk(name, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         en;
        logic [7:0] req;
        int         idx;
        bit         vld;
    } vec_t;

    function automatic vec_t mk(bit e, logic [7:0] r, int i, bit v);
        vec_t x;
        x.en = e; x.req = r; x.idx = i; x.vld = v;
        return x;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [7:0] r;
        int h, nh, eidx;
        bit eto;

        rst_n = 1'b0;
        en = 1'b0;
        req = 8'h00;
        #1;
        do_reset("reset_initial");

        // ---- directed table ----
        tbl.push_back(mk(1, 8'h04, 2, 1));   // first grant, one cycle latency
        tbl.push_back(mk(1, 8'h00, 0, 0));   // release -> idle, ptr=3
        tbl.push_back(mk(1, 8'h85, 7, 1));   // search 3..7 before 0
        tbl.push_back(mk(1, 8'h05, 0, 1));   // release 7 -> 0, no bubble
        tbl.push_back(mk(1, 8'h04, 2, 1));   // release 0 -> 2
        tbl.push_back(mk(1, 8'h00, 0, 0));   // idle, ptr=3
        tbl.push_back(mk(1, 8'hFF, 3, 1));   // full rotation starting at ptr=3
        h = 3;
        for (int g = 0; g < 8; g++) begin
            nh = (h + 1) % 8;
            r = 8'hFF & ~(8'b1 << h);
            tbl.push_back(mk(1, r, nh, 1));
            h = nh;
        end
        tbl.push_back(mk(1, 8'h00, 0, 0));   // release 3 -> ptr=4
        tbl.push_back(mk(1, 8'h20, 5, 1));   // grant 5
        tbl.push_back(mk(0, 8'h22, 5, 1));   // en low: holder keeps it
        tbl.push_back(mk(0, 8'h02, 0, 0));   // release while en low -> idle
        tbl.push_back(mk(0, 8'h02, 0, 0));   // stays idle
        tbl.push_back(mk(1, 8'h02, 1, 1));   // en back -> 1 (ptr=6)
        tbl.push_back(mk(1, 8'h00, 0, 0));   // ptr=2
        tbl.push_back(mk(1, 8'h10, 4, 1));   // drops in same cycle granted
        tbl.push_back(mk(1, 8'h00, 0, 0));   // one-cycle grant, ptr=5
        tbl.push_back(mk(1, 8'h08, 3, 1));   // 5,6,7,0,1,2,3 -> 3
        tbl.push_back(mk(1, 8'hFF, 3, 1));   // other lines ignored
        tbl.push_back(mk(1, 8'h0E, 3, 1));
        tbl.push_back(mk(1, 8'h06, 1, 1));   // release 3, ptr=4 -> 1
        tbl.push_back(mk(1, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].req);
            chk($sformatf("vec%0d", i), tbl[i].idx, tbl[i].vld, 1'b0);
        end

        // ---- asynchronous reset during a grant ----
        do_reset("reset_pre");
        step(1, 8'h10);
        chk("grant4_before_reset", 4, 1'b1, 1'b0);
        do_reset("reset_mid_grant");
        step(1, 8'h11);
        chk("ptr_zero_after_reset", 0, 1'b1, 1'b0);

        // ---- long hold: revoke with the macro, indefinite hold without ----
        do_reset("reset_hold");
        for (int s = 0; s < 12; s++) begin
            step(1, 8'h03);
            eidx = TO_EN ? (s / 4) % 2 : 0;
            eto  = TO_EN && s > 0 && (s % 4) == 0;
            chk($sformatf("hold%0d", s), eidx, 1'b1, eto);
        end

        // ---- randomized against the model ----
        do_reset("reset_rand");
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: r = 8'($urandom);
                1: r = r ^ (8'b1 << $urandom_range(0, 7));
                default: ;
            endcase
            step($urandom_range(0, 9) != 0, r);
            chk_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
